seq_pattern_detector: RTL

- Parametrised multi-bit sequence detector, the successor to the fixed two-input three-state detector FSMs.
- Compares a stream of W-bit samples against a runtime-programmable, per-bit-masked pattern of up to DEPTH steps.
- Raises a registered match pulse on each completed pattern and keeps a saturating match count.
- Modes: single-shot, or hold (match repeats while the final element repeats).

---
 rtl/seq_pattern_detector_pkg.sv | 21 ++
 rtl/seq_pattern_detector_if.sv | 23 ++
 rtl/seq_pattern_detector_step_cmp.sv | 35 +++
 rtl/seq_pattern_detector.sv | 105 ++++++++++
 4 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the masked sequence detector: operating modes and the
// per-element masked compare used by the step selector.
package seq_pattern_detector_pkg;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_HOLD   = 1'b1
    } mode_e;

    // Callers zero-extend narrower samples to this width.
    localparam int MAX_W = 64;

    function automatic logic eq(
        input logic [MAX_W-1:0] din,
        input logic [MAX_W-1:0] pat,
        input logic [MAX_W-1:0] mask
    );
        return ((din ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Sample stream and detector status bundle; the producer drives samples and
// observes the match/step status.
interface seq_pattern_detector_if #(
    parameter int W     = 2,
    parameter int LW    = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [W-1:0]     din;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [LW-1:0]    step;

    modport master (
        output in_valid, din,
        input  match, match_cnt, step
    );

    modport slave (
        input  in_valid, din,
        output match, match_cnt, step
    );
endinterface

// File: rtl/seq_pattern_detector_step_cmp.sv
// Picks pattern element sel out of the flat config vectors and compares the
// current sample against it and against element 0 (used for restarts).
module seq_pattern_detector_step_cmp
    import seq_pattern_detector_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic [W-1:0]       din,
    input  logic [DEPTH*W-1:0] cfg_pat,
    input  logic [DEPTH*W-1:0] cfg_mask,
    input  logic [LW-1:0]      sel,
    output logic               eq_step,
    output logic               eq_first
);

    logic [W-1:0] pat_sel;
    logic [W-1:0] mask_sel;

    always_comb begin
        pat_sel  = cfg_pat[W-1:0];
        mask_sel = cfg_mask[W-1:0];
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == LW'(k)) begin
                pat_sel  = cfg_pat[k*W +: W];
                mask_sel = cfg_mask[k*W +: W];
            end
        end
    end

    assign eq_step  = eq(MAX_W'(din), MAX_W'(pat_sel), MAX_W'(mask_sel));
    assign eq_first = eq(MAX_W'(din), MAX_W'(cfg_pat[W-1:0]), MAX_W'(cfg_mask[W-1:0]));

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable masked sequence detector with single-shot and hold
// modes, a registered match pulse and a saturating match counter.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter  int W     = 2,
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [DEPTH*W-1:0] cfg_pat,
    input  logic [DEPTH*W-1:0] cfg_mask,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_hold,
    seq_pattern_detector_if.slave bus
);

    mode_e            mode;
    logic [LW-1:0]    len_eff;
    logic [LW-1:0]    cmp_sel;
    logic             eq_step;
    logic             eq_first;
    logic             complete;
    logic [LW-1:0]    step_q,  step_next;
    logic             match_q, match_next;
    logic [CNT_W-1:0] cnt_q,   cnt_next;

    assign mode = mode_e'(cfg_hold);

    always_comb begin
        if (cfg_len == '0) begin
            len_eff = LW'(1);
        end else if (cfg_len > LW'(DEPTH)) begin
            len_eff = LW'(DEPTH);
        end else begin
            len_eff = cfg_len;
        end
    end

    // While holding at step L the sample is compared against the final element.
    assign cmp_sel = (step_q >= len_eff) ? (len_eff - LW'(1)) : step_q;

    seq_pattern_detector_step_cmp #(
        .W     (W),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_step_cmp (
        .din      (bus.din),
        .cfg_pat  (cfg_pat),
        .cfg_mask (cfg_mask),
        .sel      (cmp_sel),
        .eq_step  (eq_step),
        .eq_first (eq_first)
    );

    always_comb begin
        step_next  = step_q;
        match_next = 1'b0;
        cnt_next   = cnt_q;
        complete   = 1'b0;
        if (clr) begin
            step_next = '0;
            cnt_next  = '0;
        end else if (bus.in_valid) begin
            if (eq_step && ((step_q >= len_eff) || (step_q + LW'(1) == len_eff))) begin
                complete = 1'b1;
            end else if (eq_step) begin
                step_next = step_q + LW'(1);
            end else if (eq_first && (len_eff == LW'(1))) begin
                complete = 1'b1;
            end else begin
                step_next = eq_first ? LW'(1) : '0;
            end

            // Single-shot does not reuse the completing sample as a new step 0.
            if (complete) begin
                match_next = 1'b1;
                step_next  = (mode == MODE_HOLD) ? len_eff : '0;
                if (cnt_q != '1) begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            step_q  <= step_next;
            match_q <= match_next;
            cnt_q   <= cnt_next;
        end
    end

    assign bus.step      = step_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;

endmodule
